// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect flushes,
// whole-pipe freeze on data-memory wait, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter logic [3:0]  OP1_LW       = 4'b1001,
    parameter logic [3:0]  OP1_BR       = 4'b0010,
    parameter logic [3:0]  OP1_JAL      = 4'b1011,
    parameter int unsigned LOAD_STALLS  = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  idRs1,
    input  logic [3:0]  idRs2,
    input  logic        idUsesRs1,
    input  logic        idUsesRs2,
    input  logic [3:0]  exInstType,
    input  logic        exBrTaken,
    input  logic [3:0]  exWrtIndex,
    input  logic        exRegWrEn,
    input  logic        memReq,
    input  logic        memReady,
    output logic        pcWrEn,
    output logic        pcSel,
    output logic        ifIdWrEn,
    output logic        ifIdFlush,
    output logic        idExWrEn,
    output logic        idExFlush,
    output logic        exMemWrEn,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {
        StRun,
        StLdStall,
        StFlush,
        StMemWait
    } state_e;

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    state_e      eff_state;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic redirect;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    assign mem_stall = memReq & ~memReady;
    assign redirect  = ((exInstType == OP1_BR) & exBrTaken) | (exInstType == OP1_JAL);
    assign rs1_hit   = idUsesRs1 & (idRs1 == exWrtIndex);
    assign rs2_hit   = idUsesRs2 & (idRs2 == exWrtIndex);
    assign load_use  = (exInstType == OP1_LW) & exRegWrEn & (exWrtIndex != 4'd0) &
                       (rs1_hit | rs2_hit);

    // A released memory wait behaves exactly like the state it interrupted.
    assign eff_state = (state_q == StMemWait) ? ret_q : state_q;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        pcWrEn    = 1'b1;
        pcSel     = 1'b0;
        ifIdWrEn  = 1'b1;
        ifIdFlush = 1'b0;
        idExWrEn  = 1'b1;
        idExFlush = 1'b0;
        exMemWrEn = 1'b1;

        if (mem_stall) begin
            pcWrEn    = 1'b0;
            ifIdWrEn  = 1'b0;
            idExWrEn  = 1'b0;
            exMemWrEn = 1'b0;
            state_d   = StMemWait;
            if (state_q != StMemWait) begin
                ret_d = state_q;
            end
        end else begin
            state_d = eff_state;
            ret_d   = StRun;
            case (eff_state)
                StRun: begin
                    if (redirect) begin
                        pcSel     = 1'b1;
                        ifIdFlush = 1'b1;
                        idExFlush = 1'b1;
                        if (FLUSH_CYCLES > 0) begin
                            state_d = StFlush;
                            cnt_d   = 3'(FLUSH_CYCLES);
                        end
                    end else if (load_use) begin
                        pcWrEn    = 1'b0;
                        ifIdWrEn  = 1'b0;
                        idExFlush = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            state_d = StLdStall;
                            cnt_d   = 3'(LOAD_STALLS - 1);
                        end
                    end
                end
                StLdStall: begin
                    pcWrEn    = 1'b0;
                    ifIdWrEn  = 1'b0;
                    idExFlush = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    // EX holds a bubble here, so any redirect decode is stale.
                    idExFlush = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end

        if (!reset) begin
            pcWrEn    = 1'b0;
            pcSel     = 1'b0;
            ifIdWrEn  = 1'b0;
            ifIdFlush = 1'b1;
            idExWrEn  = 1'b0;
            idExFlush = 1'b1;
            exMemWrEn = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pcWrEn && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stallCount = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            ret_q       <= StRun;
            cnt_q       <= 3'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
